seg7_bin2bcd_ctrl: RTL and testbench
====================================

// Module: seg7_bin2bcd_ctrl
// PURPOSE
//  Sequential binary-to-BCD controller that sits in front of the 8-digit 7-segment decoder.
//  - Accepts a binary value over a valid/ready handshake.
//  - Converts it by iterative double-dabble, one bit per clock.
//  - Publishes a packed 32-bit BCD word (digit 0 = bits [3:0]) for the display bank.
//  - oDIG changes only atomically at the end of a conversion, so the display never flickers.
// PARAMETERS
//  BIN_W    27           width of iBIN; 27 bits covers 99,999,999
//  DIGITS   8            BCD digits produced; oDIG is 4*DIGITS wide
//  BCD_MAX  99_999_999   saturation threshold, derived as 10**DIGITS-1
// PORTS
//  iCLK    in   1         single system clock; all state on rising edge
//  iRST    in   1         synchronous, active-high reset
//  iBIN    in   BIN_W     binary value to convert
//  iVALID  in   1         request; sampled only while oREADY=1
//  oREADY  out  1         1 = idle, will accept on the next edge
//  oDIG    out  4*DIGITS  packed BCD result, registered; feeds display iDIG
//  oDONE   out  1         one-cycle pulse, coincident with oDIG update
//  oOVF    out  1         registered with oDIG; 1 = input exceeded BCD_MAX, result saturated
//  oNEG    out  1         registered with oDIG; sign flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (iRST=1 at an edge): state IDLE, oDIG=0, oDONE=0, oOVF=0, oNEG=0, oREADY=1.
//  - Reset mid-conversion aborts the conversion; the partial result is discarded.
//  States:
//  - IDLE -> CONV on iVALID&&oREADY: latch iBIN into the shift reg, clear the BCD accumulator,
//    bit counter = BIN_W-1, oREADY=0.
//  - CONV, each cycle:
//    - every accumulator nibble >=5 gets +3;
//    - then shift {acc,shift} left by 1;
//    - counter decrements.
//    At counter==0 go to DONE.
//  - DONE (one cycle, no stall):
//    - oDIG <= acc (or the saturated value);
//    - oDONE=1, oOVF and oNEG updated;
//    - next state IDLE with oREADY=1.
//  - Latency: accept at edge T; oDIG/oDONE valid after edge T+BIN_W+1; next accept at T+BIN_W+2.
//  Handshake:
//  - iVALID while oREADY=0 is ignored and not queued.
//  - iBIN is sampled only at the accept edge; later changes have no effect.
//  Overflow: latched input > BCD_MAX gives oDIG = all-9s (0x99999999) and oOVF=1.
//  - Conversion still runs the full BIN_W cycles (constant latency).
//  Arithmetic:
//  - Accumulator is 4*DIGITS+1 bits wide; the top bit is only a guard for the overflow check.
//  - The add-3 correction never carries across nibble boundaries.
//  Back-to-back: iVALID held high gives one conversion per BIN_W+2 cycles; no input is dropped
//  while oREADY=1.
// CONFIGURATION
//  SEG7_SIGNED_EN defined:
//  - iBIN is two's complement; the magnitude |iBIN| is converted;
//  - oNEG=1 for negative inputs;
//  - -2^(BIN_W-1) is handled by a BIN_W+1-bit magnitude path;
//  - saturation applies to the magnitude.
//  SEG7_SIGNED_EN undefined:
//  - iBIN is unsigned; oNEG is constant 0; no magnitude logic.
// STRUCTURE
//  seg7_pkg:
//  - state enum {IDLE, CONV, DONE};
//  - BCD_NIBBLE_W=4;
//  - function bcd_max(DIGITS) returning the saturation constant.
//  Sub-module seg7_dd_step:
//  - combinational, one per conversion step;
//  - applies add-3 to every nibble >=5, then shifts in one bit;
//  - instantiated once, used iteratively by the CONV state.
// TESTING
//  1. Reset, then iBIN=0 -> after BIN_W+1 edges oDIG=0x00000000, oDONE one pulse, oOVF=0.
//  2. iBIN=12_345_678 -> oDIG=0x12345678 exactly BIN_W+1 edges after accept; oREADY low
//     throughout CONV.
//  3. iBIN=99_999_999 -> 0x99999999, oOVF=0.
//     Then iBIN=100_000_000 -> 0x99999999, oOVF=1.
//  4. iVALID pulsed with iBIN=42 during a busy conversion of 7 -> result 0x00000007 only;
//     42 never appears; oDIG holds its old value until DONE.
//  5. iRST asserted mid-CONV -> next cycle oDIG=0, oREADY=1, no oDONE.
//     A fresh request of 905 then yields 0x00000905.
//  6. SEG7_SIGNED_EN: iBIN=-5 -> oDIG=0x00000005, oNEG=1.
//     iBIN=-2^26 -> 0x67108864, oNEG=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BCD_NIBBLE_W = 4;

    // Largest value representable in 'digits' decimal digits (10**digits - 1).
    function automatic longint unsigned bcd_max(input int unsigned digits);
        longint unsigned r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/seg7_dd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module seg7_dd_step
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS = 8,
    localparam int unsigned DIG_W = BCD_NIBBLE_W * DIGITS
) (
    input  logic [DIG_W-1:0] i_acc,
    input  logic             i_bit,
    output logic [DIG_W:0]   o_acc
);

    logic [DIG_W-1:0] w_adj;

    // Correction stays inside each nibble (max 9+3=12), so no cross-nibble carry exists.
    always_comb begin
        w_adj = i_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_acc[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] >= 4'd5) begin
                w_adj[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] =
                    i_acc[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] + 4'd3;
            end
        end
        o_acc = {w_adj, i_bit};
    end

endmodule

// File: rtl/seg7_bin2bcd_ctrl.sv
// Iterative binary-to-BCD converter feeding the 7-segment display bank.
// Define SEG7_SIGNED_EN to treat iBIN as two's complement and convert its magnitude.
module seg7_bin2bcd_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned DIGITS = 8,
    localparam int unsigned DIG_W = BCD_NIBBLE_W * DIGITS
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [BIN_W-1:0] iBIN,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [DIG_W-1:0] oDIG,
    output logic             oDONE,
    output logic             oOVF,
    output logic             oNEG
);

    localparam int unsigned     ACC_W   = DIG_W + 1;
    localparam int unsigned     CNT_W   = $clog2(BIN_W);
    localparam longint unsigned BCD_MAX = bcd_max(DIGITS);
    localparam logic [DIG_W-1:0] ALL_NINES = DIG_W'({DIGITS{4'd9}});

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic [BIN_W-1:0]   w_mag;
    logic               w_neg;
    logic [ACC_W-1:0]   w_step;
    logic               w_ovf;

    logic [BIN_W-1:0]   r_shift;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic               r_neg_pend;
    logic               r_ready;
    logic [DIG_W-1:0]   r_dig;
    logic               r_done;
    logic               r_ovf;
    logic               r_neg;

`ifdef SEG7_SIGNED_EN
    // Negating the most negative value yields 2**(BIN_W-1), which still fits as unsigned.
    assign w_neg = iBIN[BIN_W-1];
    assign w_mag = w_neg ? (~iBIN + BIN_W'(1)) : iBIN;
`else
    assign w_neg = 1'b0;
    assign w_mag = iBIN;
`endif

    seg7_dd_step #(
        .DIGITS (DIGITS)
    ) u_dd_step (
        .i_acc (r_acc[DIG_W-1:0]),
        .i_bit (r_shift[BIN_W-1]),
        .o_acc (w_step)
    );

    // Guard bit catches any spill past the top digit in addition to the latched compare.
    assign w_ovf = r_ovf_pend | r_acc[ACC_W-1];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (iVALID && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_neg_pend <= 1'b0;
            r_ready    <= 1'b1;
            r_dig      <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift    <= w_mag;
                        r_acc      <= '0;
                        r_cnt      <= CNT_W'(BIN_W - 1);
                        r_ovf_pend <= (64'(w_mag) > BCD_MAX);
                        r_neg_pend <= w_neg;
                        r_ready    <= 1'b0;
                    end
                end
                CONV: begin
                    r_acc   <= w_step;
                    r_shift <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                DONE: begin
                    r_dig   <= w_ovf ? ALL_NINES : r_acc[DIG_W-1:0];
                    r_ovf   <= w_ovf;
                    r_neg   <= r_neg_pend;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oREADY = r_ready;
    assign oDIG   = r_dig;
    assign oDONE  = r_done;
    assign oOVF   = r_ovf;
    assign oNEG   = r_neg;

endmodule

// File: tb/tb_seg7_bin2bcd_ctrl.sv
// Scoreboard bench for seg7_bin2bcd_ctrl: expected words queued at accept, checked on oDONE.
module tb_seg7_bin2bcd_ctrl;

    localparam int unsigned BIN_W  = 27;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned DIG_W  = 4 * DIGITS;

    typedef struct {
        logic [DIG_W-1:0] dig;
        logic             ovf;
        logic             neg;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [BIN_W-1:0] bin;
    logic             valid;
    logic             ready;
    logic [DIG_W-1:0] dig;
    logic             done;
    logic             ovf;
    logic             neg;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_accept = 0;
    exp_t sb[$];

    seg7_bin2bcd_ctrl #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iBIN   (bin),
        .iVALID (valid),
        .oREADY (ready),
        .oDIG   (dig),
        .oDONE  (done),
        .oOVF   (ovf),
        .oNEG   (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: decimal digit extraction, independent of double-dabble.
    function automatic exp_t model(input logic [BIN_W-1:0] v);
        exp_t             e;
        logic [BIN_W-1:0] m;
        e.neg = 1'b0;
        m     = v;
`ifdef SEG7_SIGNED_EN
        if (v[BIN_W-1]) begin
            e.neg = 1'b1;
            m     = BIN_W'(0) - v;
        end
`endif
        e.ovf = (m > 27'd99_999_999);
        e.dig = '0;
        if (e.ovf) begin
            e.dig = 32'h9999_9999;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                e.dig[i*4 +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
        e.cyc = 0;
        return e;
    endfunction

    // Wait for ready, present v for one accept edge, then scramble iBIN.
    task automatic send(input logic [BIN_W-1:0] v, input bit track);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
        bin   = v;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid       = 1'b0;
        bin         = BIN_W'($urandom);
        last_accept = cyc;
        if (track) begin
            e     = model(v);
            e.cyc = cyc + BIN_W + 1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dig", 64'(dig), 64'(e.dig));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("neg", 64'(neg), 64'(e.neg));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int   busy_ready;
        int   dig_changes;
        int   prev_acc;
        logic [DIG_W-1:0] old_dig;

        rst   = 1'b1;
        valid = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dig",   64'(dig),   64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done",  64'(done),  64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        check("rst_neg",   64'(neg),   64'd0);

        send(27'd0, 1'b1);
        drain();

        // Ready must stay low for the whole conversion.
        send(27'd12_345_678, 1'b1);
        busy_ready = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ready && !done) busy_ready++;
        end
        check("ready_busy", 64'(busy_ready), 64'd0);
        drain();

        send(27'd99_999_999, 1'b1);
        drain();
        send(27'd100_000_000, 1'b1);
        drain();
        send(27'h7FF_FFFF, 1'b1);
        drain();

        // A request during a busy conversion is dropped; oDIG holds until DONE.
        old_dig = dig;
        send(27'd7, 1'b1);
        dig_changes = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 5) begin
                bin   = 27'd42;
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            if (!done && dig !== old_dig) dig_changes++;
        end
        valid = 1'b0;
        check("dig_hold", 64'(dig_changes), 64'd0);
        drain();
        repeat (BIN_W + 5) @(negedge clk);

        // Abort mid-conversion, then a fresh request.
        send(27'd123_456, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_dig",   64'(dig),   64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done",  64'(done),  64'd0);
        repeat (BIN_W + 5) @(negedge clk);
        send(27'd905, 1'b1);
        drain();

`ifdef SEG7_SIGNED_EN
        send(BIN_W'(-5), 1'b1);
        drain();
        send(27'h400_0000, 1'b1);
        drain();
`endif

        // Back-to-back stream: one accept every BIN_W+2 cycles.
        send(27'(1 + $urandom_range(0, 999)), 1'b1);
        prev_acc = last_accept;
        for (int i = 0; i < 6; i++) begin
            send(27'($urandom_range(0, 134_217_727)), 1'b1);
            check("b2b_interval", 64'(last_accept - prev_acc), 64'(BIN_W + 2));
            prev_acc = last_accept;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
